// File: rtl/system_controller.sv
// Sequencing controller for the memory shift register: turns single host commands into
// mutually exclusive load/run/output strobes, counting bits and generations.
module system_controller #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [GEN_WIDTH-1:0] cmd_count,
  input  logic                 serial_in_valid,
  input  logic                 serial_out_ready,
  output logic                 load_mode,
  output logic                 run_mode,
  output logic                 output_mode,
  output logic                 serial_out_valid,
  output logic [GEN_WIDTH-1:0] gen_remaining,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_OUTPUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b01,
    S_RUN    = 2'b10,
    S_OUTPUT = 2'b11
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [GEN_WIDTH-1:0]   gen_q;
  logic                   done_q;
  logic                   sov_q;
  logic                   bit_strobe;

  // Mode strobes follow the handshake inputs combinationally so a stall withholds them in-cycle.
  always_comb begin
    load_mode   = 1'b0;
    run_mode    = 1'b0;
    output_mode = 1'b0;
    case (state_q)
      S_LOAD:   load_mode   = serial_in_valid;
      S_RUN:    run_mode    = 1'b1;
      S_OUTPUT: output_mode = serial_out_ready;
      default:  run_mode    = 1'b0;
    endcase
  end

  assign bit_strobe       = load_mode | output_mode;
  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign serial_out_valid = sov_q;
  assign gen_remaining    = gen_q;

  // Command sequencing, bit/generation counting and the registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gen_q     <= '0;
      done_q    <= 1'b0;
      sov_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      sov_q  <= output_mode;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                state_q   <= S_LOAD;
                bit_cnt_q <= '0;
              end
              OP_OUTPUT: begin
                state_q   <= S_OUTPUT;
                bit_cnt_q <= '0;
              end
              OP_RUN: begin
                // A zero-generation run completes immediately without touching memory.
                if (cmd_count != '0) begin
                  state_q <= S_RUN;
                  gen_q   <= cmd_count;
                end else begin
                  done_q  <= 1'b1;
                end
              end
              OP_NOP:  state_q <= S_IDLE;
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_LOAD, S_OUTPUT: begin
          if (bit_strobe) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= S_IDLE;
              bit_cnt_q <= '0;
              done_q    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        S_RUN: begin
          gen_q <= gen_q - GEN_WIDTH'(1);
          if (gen_q == GEN_WIDTH'(1)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_controller.sv
// Bench for system_controller (DATA_SIZE=8) with a shift-register memory model and an
// output-bit scoreboard.
module tb_system_controller;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_OUTPUT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_count = 16'd0;
  logic        siv = 1'b0;
  logic        sor = 1'b0;
  logic        sor_rand = 1'b0;

  logic        cmd_ready, load_mode, run_mode, output_mode, sov, busy, done;
  logic [15:0] gen_remaining;

  int n_checks = 0;
  int n_errors = 0;
  int ld_cnt = 0, run_cnt = 0, out_cnt = 0;

  logic [7:0] pat = 8'hA5;
  logic [7:0] mem = 8'h00;
  logic       sout = 1'b0;
  logic [2:0] ld_idx = 3'd0;
  logic       exp_q[$];

  system_controller #(.DATA_SIZE(8), .GEN_WIDTH(16)) dut (
    .clk(clk), .reset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .serial_in_valid(siv),
    .serial_out_ready(sor), .load_mode(load_mode), .run_mode(run_mode),
    .output_mode(output_mode), .serial_out_valid(sov), .gen_remaining(gen_remaining),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: shift in on load, rotate and emit a registered bit on output.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready && cmd_op == OP_LOAD) ld_idx <= 3'd0;
    if (load_mode) begin
      mem    <= {mem[6:0], pat[3'd7 - ld_idx]};
      ld_idx <= ld_idx + 3'd1;
    end else if (output_mode) begin
      mem  <= {mem[6:0], mem[7]};
      sout <= mem[7];
    end
  end

  // Random or steady sink readiness.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sor = sor_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: strobe counts, mode exclusivity and the output-bit scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_mode) ld_cnt++;
      if (run_mode) run_cnt++;
      if (output_mode) out_cnt++;
      check("mode_excl", {31'd0, ($countones({load_mode, run_mode, output_mode}) <= 1)}, 32'd1);
      if (sov) begin
        if (exp_q.size() == 0) check("sb_unexpected_bit", {31'd0, sout}, 32'd2);
        else check("out_bit", {31'd0, sout}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
    int w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("issue_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    if (op == OP_OUTPUT) for (int b = 7; b >= 0; b--) exp_q.push_back(pat[b]);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_modes"}, {29'd0, load_mode, run_mode, output_mode}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_sov"}, {31'd0, sov}, 32'd0);
    check({tag, "_gen"}, {16'd0, gen_remaining}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int b0, b1, k;

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);

    // NOP is consumed silently
    issue(OP_NOP, 16'd0);
    @(negedge clk);
    check("nop_done", {31'd0, done}, 32'd0);
    check("nop_busy", {31'd0, busy}, 32'd0);

    // LOAD 0xA5, no stalls
    siv = 1'b1;
    b0 = ld_cnt;
    issue(OP_LOAD, 16'd0);
    wait_done(50, lat);
    check("load_lat", lat, 32'd9);
    check("load_strobes", ld_cnt - b0, 32'd8);
    check("load_ready_at_done", {31'd0, cmd_ready}, 32'd1);
    check("load_mem", {24'd0, mem}, 32'h0000_00A5);

    // LOAD with toggling valid; a RUN held on cmd_valid must be ignored
    b0 = ld_cnt;
    b1 = run_cnt;
    issue(OP_LOAD, 16'd0);
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    cmd_count = 16'd5;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i + 1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        break;
      end
      check("busy_ignore_gen", {16'd0, gen_remaining}, 32'd0);
      @(posedge clk);
      #1;
      siv = ((i + 1) % 2 == 0);
    end
    cmd_valid = 1'b0;
    check("toggle_lat", lat, 32'd16);
    check("toggle_strobes", ld_cnt - b0, 32'd8);
    check("toggle_no_run", run_cnt - b1, 32'd0);
    check("toggle_mem", {24'd0, mem}, 32'h0000_00A5);
    siv = 1'b0;

    // RUN 3, back-to-back with the previous done
    issue(OP_RUN, 16'd3);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("run_mode", {31'd0, run_mode}, (i <= 3) ? 32'd1 : 32'd0);
      check("run_gen", {16'd0, gen_remaining}, (i <= 3) ? 32'(4 - i) : 32'd0);
      check("run_done", {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("run_done_single", {31'd0, done}, 32'd0);

    // RUN 0
    b1 = run_cnt;
    issue(OP_RUN, 16'd0);
    @(negedge clk);
    check("run0_done", {31'd0, done}, 32'd1);
    check("run0_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("run0_done_single", {31'd0, done}, 32'd0);
    check("run0_no_run", run_cnt - b1, 32'd0);

    // OUTPUT twice back-to-back with random readiness
    sor_rand = 1'b1;
    b0 = out_cnt;
    issue(OP_OUTPUT, 16'd0);
    wait_done(300, lat);
    check("out1_sov_at_done", {31'd0, sov}, 32'd1);
    issue(OP_OUTPUT, 16'd0);
    wait_done(300, lat);
    check("out2_sov_at_done", {31'd0, sov}, 32'd1);
    @(posedge clk);
    #1;
    check("out_strobes", out_cnt - b0, 32'd16);
    check("out_sb_empty", exp_q.size(), 32'd0);
    check("out_mem", {24'd0, mem}, 32'h0000_00A5);

    // Reset during bit 4 of OUTPUT
    sor_rand = 1'b0;
    @(posedge clk);
    #2;
    issue(OP_OUTPUT, 16'd0);
    k = 0;
    for (int i = 0; i < 30 && k < 5; i++) begin
      @(negedge clk);
      if (output_mode) k++;
    end
    check("rst_reached_bit4", k, 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/system_controller.md
# system_controller

Sequencing FSM for the system memory shift register: converts a single-command interface into the mutually exclusive `load_mode`, `run_mode` and `output_mode` strobes that drive the memory.

It counts serial bits in and out so every load and readout covers exactly `DATA_SIZE` bits, which keeps the circular readout buffer aligned. It counts generations during run. It sits between the external host/serial interface and the memory plus grid calculator.

## Interface
- `DATA_SIZE`, default 64: memory width in bits. Must be ≥ 2.
- `GEN_WIDTH`, default 16: width of the generation-count field and the remaining-generations counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_op`  in  2  command opcode: 00 NOP, 01 LOAD, 10 RUN, 11 OUTPUT.
- `cmd_count`  in  GEN_WIDTH  generation count. Sampled only for RUN.
- `serial_in_valid`  in  1  external serial source presents a bit this cycle.
- `serial_out_ready`  in  1  external sink accepts a bit this cycle.
- `load_mode`  out  1  shift one serial bit into memory this cycle.
- `run_mode`  out  1  load memory from the grid calculator this cycle (one generation).
- `output_mode`  out  1  rotate memory and emit one bit this cycle.
- `serial_out_valid`  out  1  memory `serial_out` holds a valid bit this cycle.
- `gen_remaining`  out  GEN_WIDTH  generations still to run.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a LOAD, RUN or OUTPUT command completes.

## Operation
- States and their outputs:
  - IDLE: `cmd_ready` = 1; all mode outputs low.
  - LOAD: `load_mode` = `serial_in_valid`.
  - RUN: `run_mode` = 1 every cycle.
  - OUTPUT: `output_mode` = `serial_out_ready`.
- Mode decode is combinational from the state register and the handshake inputs. At most one mode output is high in any cycle.
- Command acceptance: `cmd_valid & cmd_ready` at a rising edge.
  - LOAD: go to LOAD and clear `bit_cnt`.
  - OUTPUT: go to OUTPUT and clear `bit_cnt`.
  - RUN with `cmd_count` ≠ 0: go to RUN and set `gen_remaining` = `cmd_count`.
  - RUN with `cmd_count` = 0: stay in IDLE and pulse `done` the next cycle; `run_mode` never asserts.
  - NOP: consumed, no state change, no `done`.
- `bit_cnt` width is $clog2(DATA_SIZE). It increments on each cycle in which the state's mode output is high.
- LOAD/OUTPUT exit: when the mode output is high and `bit_cnt` = DATA_SIZE−1, go to IDLE and set `done` for one cycle. Exactly DATA_SIZE strobes occur per command.
- RUN: `gen_remaining` decrements each cycle. When it is 1, the state goes to IDLE, `gen_remaining` goes to 0 and `done` pulses. Exactly `cmd_count` `run_mode` cycles occur.
- `serial_out_valid` is `output_mode` registered by one cycle, matching the memory's registered `serial_out`.
- There is no abort. A started LOAD or OUTPUT always runs to DATA_SIZE bits, preserving memory alignment. Only `reset_n` interrupts a command.
- Stalls: if `serial_in_valid` or `serial_out_ready` is low, the strobe is withheld. The counter and state hold indefinitely.

## Timing
- Reset values (`reset_n` low, asynchronous):
  - State = IDLE.
  - `bit_cnt` = 0, `gen_remaining` = 0.
  - `done` = 0, `serial_out_valid` = 0.
  - Hence `cmd_ready` = 1, `busy` = 0, all mode outputs 0.
- Reset mid-command: the controller returns to IDLE immediately and all mode outputs drop asynchronously. Memory contents become undefined from the host's view.
- Command accepted at edge N: the first mode strobe can be high in cycle N+1.
- LOAD/OUTPUT with no stalls: strobes occupy cycles N+1..N+DATA_SIZE. `done` and `cmd_ready` are high in cycle N+DATA_SIZE+1.
- OUTPUT: the last `serial_out_valid` coincides with `done`.
- RUN with count k: `run_mode` is high in cycles N+1..N+k. `done` is high in cycle N+k+1.
- A new command may be accepted in the same cycle `done` is high (back-to-back).

## Test plan
All scenarios use DATA_SIZE = 8.

- Reset then idle: assert `reset_n` = 0 mid-cycle.
  - Required: all outputs go to reset values immediately; `cmd_ready` = 1.
- LOAD 0xA5, `serial_in_valid` held high, paired with the memory model.
  - Required: exactly 8 `load_mode` cycles; `done` one cycle after the last strobe; memory = 0xA5.
- LOAD with `serial_in_valid` toggling 1,0,1,0…
  - Required: 8 strobes spread over 15 cycles; `bit_cnt` holds on 0 cycles; `cmd_valid` ignored while busy.
- RUN count 3.
  - Required: `run_mode` high for exactly 3 cycles; `gen_remaining` reads 3,2,1 then 0; single `done` pulse.
  - Also RUN count 0: no `run_mode`; `done` the next cycle.
- OUTPUT twice back-to-back after LOAD 0xA5, `serial_out_ready` random.
  - Required: `serial_out_valid` bits read 10100101 both times; memory still holds 0xA5 afterwards.
- `reset_n` pulsed low at bit 4 of OUTPUT.
  - Required: `output_mode` drops immediately; state returns to IDLE; no `done`.
